// File: rtl/paddle_oneshot_if.sv
// rtl/paddle_oneshot_if.sv - paddle trigger, position and one-shot pulse bundle
interface paddle_oneshot_if;
  logic       PAD_TRG_N;
  logic [1:0] MODE;
  logic [7:0] PAD1_POS;
  logic [7:0] PAD2_POS;
  logic [1:0] PAD_UP;
  logic [1:0] PAD_DN;
  logic       PAD1_OUT;
  logic       PAD2_OUT;
  logic [7:0] POS1;
  logic [7:0] POS2;

  modport master (
    output PAD_TRG_N, MODE, PAD1_POS, PAD2_POS, PAD_UP, PAD_DN,
    input  PAD1_OUT, PAD2_OUT, POS1, POS2
  );

  modport slave (
    input  PAD_TRG_N, MODE, PAD1_POS, PAD2_POS, PAD_UP, PAD_DN,
    output PAD1_OUT, PAD2_OUT, POS1, POS2
  );
endinterface

// File: rtl/paddle_oneshot.sv
// rtl/paddle_oneshot.sv - two non-retriggerable 555-style paddle one-shots
module paddle_oneshot #(
  parameter int MIN_CYCLES  = 7280,
  parameter int STEP_CYCLES = 364,
  parameter int SPEED       = 4,
  parameter int CNT_W       = 17
) (
  input logic              CLK,
  input logic              FPGA_RESET_N,
  paddle_oneshot_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [8:0] SPD9 = 9'(SPEED);

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [7:0]       pos_q   [2];
  logic [7:0]       pos_d   [2];
  logic [7:0]       rel_q   [2];
  logic [7:0]       rel_d   [2];
  logic             out_q   [2];
  logic             out_d   [2];
  logic [7:0]       abs_pos [2];
  logic             trg_d;
  logic             trg_evt;

  // trg_d resets low so a trigger already low at reset release is not an edge
  assign trg_evt    = !bus.PAD_TRG_N && trg_d;
  assign abs_pos[0] = bus.PAD1_POS;
  assign abs_pos[1] = bus.PAD2_POS;

  function automatic logic [CNT_W-1:0] last_count(input logic [7:0] p);
    return CNT_W'(MIN_CYCLES) + CNT_W'(p) * CNT_W'(STEP_CYCLES) - CNT_W'(1);
  endfunction

  function automatic logic [7:0] rel_next(input logic [7:0] r, input logic up, input logic dn);
    logic [8:0] r9;
    r9 = {1'b0, r};
    if (up && !dn) return (r9 < SPD9) ? 8'd0 : 8'(r9 - SPD9);
    if (dn && !up) return ((r9 + SPD9) > 9'd255) ? 8'd255 : 8'(r9 + SPD9);
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pos_d[i]   = pos_q[i];
      rel_d[i]   = rel_q[i];
      out_d[i]   = out_q[i];
      // relative register steps once per frame whatever the mode or channel state
      if (trg_evt) rel_d[i] = rel_next(rel_q[i], bus.PAD_UP[i], bus.PAD_DN[i]);
      case (state_q[i])
        IDLE: begin
          if (trg_evt) begin
            pos_d[i]   = bus.MODE[i] ? rel_q[i] : abs_pos[i];
            cnt_d[i]   = last_count(pos_d[i]);
            out_d[i]   = 1'b1;
            state_d[i] = ACTIVE;
          end
        end
        ACTIVE: begin
          if (cnt_q[i] == '0) begin
            out_d[i]   = 1'b0;
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      trg_d <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pos_q[i]   <= 8'd128;
        rel_q[i]   <= 8'd128;
        out_q[i]   <= 1'b0;
      end
    end else begin
      trg_d <= bus.PAD_TRG_N;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pos_q[i]   <= pos_d[i];
        rel_q[i]   <= rel_d[i];
        out_q[i]   <= out_d[i];
      end
    end
  end

  assign bus.PAD1_OUT = out_q[0];
  assign bus.PAD2_OUT = out_q[1];
  assign bus.POS1     = pos_q[0];
  assign bus.POS2     = pos_q[1];

endmodule

// File: tb/tb_paddle_oneshot.sv
// tb/tb_paddle_oneshot.sv - directed bench with pulse-width scoreboard for paddle_oneshot
module tb_paddle_oneshot;
  localparam int MIN  = 40;
  localparam int STEP = 2;
  localparam int SPD  = 4;

  typedef struct {
    int w;
    int p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  paddle_oneshot_if bus ();

  paddle_oneshot #(
    .MIN_CYCLES(MIN), .STEP_CYCLES(STEP), .SPEED(SPD), .CNT_W(17)
  ) dut (
    .CLK(clk), .FPGA_RESET_N(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   vectors = 0;
  int   miscompares = 0;
  int   hi1 = 0;
  int   hi2 = 0;

  function automatic int width(int p);
    return MIN + p * STEP;
  endfunction

  task automatic check(string tag, logic [31:0] obs, int expv);
    vectors++;
    assert (obs === 32'(expv)) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // scoreboard: measure each completed pulse and compare with the queued expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      hi1 = 0;
      hi2 = 0;
    end else begin
      if (bus.PAD1_OUT) hi1++;
      else if (hi1 > 0) begin
        if (q1.size() == 0) check("p1_unexpected", hi1, 0);
        else begin
          e1 = q1.pop_front();
          check("p1_width", hi1, e1.w);
          check("p1_pos", 32'(bus.POS1), e1.p);
        end
        hi1 = 0;
      end
      if (bus.PAD2_OUT) hi2++;
      else if (hi2 > 0) begin
        if (q2.size() == 0) check("p2_unexpected", hi2, 0);
        else begin
          e2 = q2.pop_front();
          check("p2_width", hi2, e2.w);
          check("p2_pos", 32'(bus.POS2), e2.p);
        end
        hi2 = 0;
      end
    end
  end

  task automatic wait_idle(int timeout);
    int n = 0;
    while ((bus.PAD1_OUT || bus.PAD2_OUT) && n < timeout) begin
      @(negedge clk);
      n++;
    end
    if (n >= timeout) check("idle_timeout", n, -1);
    repeat (3) @(negedge clk);
  endtask

  task automatic trigger(int p1, int p2);
    q1.push_back('{width(p1), p1});
    q2.push_back('{width(p2), p2});
    @(negedge clk);
    bus.PAD_TRG_N = 1'b0;
    @(negedge clk);
    check("rise1", bus.PAD1_OUT, 1);
    check("rise2", bus.PAD2_OUT, 1);
    bus.PAD_TRG_N = 1'b1;
  endtask

  task automatic fire(int p1, int p2);
    trigger(p1, p2);
    wait_idle(2000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out1", bus.PAD1_OUT, 0);
    check("rst_out2", bus.PAD2_OUT, 0);
    check("rst_pos1", bus.POS1, 128);
    check("rst_pos2", bus.POS2, 128);
    q1.delete();
    q2.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int seen;
    int r1;
    rst_n         = 1'b0;
    bus.PAD_TRG_N = 1'b0;
    bus.MODE      = 2'b00;
    bus.PAD1_POS  = 8'd0;
    bus.PAD2_POS  = 8'd255;
    bus.PAD_UP    = 2'b00;
    bus.PAD_DN    = 2'b00;
    repeat (3) @(negedge clk);
    check("init_out1", bus.PAD1_OUT, 0);
    check("init_pos1", bus.POS1, 128);
    check("init_pos2", bus.POS2, 128);
    #2 rst_n = 1'b1;

    // trigger held low through reset release must not fire
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.PAD1_OUT || bus.PAD2_OUT) seen++;
    end
    check("held_low_no_pulse", seen, 0);
    bus.PAD_TRG_N = 1'b1;
    repeat (2) @(negedge clk);

    // absolute extremes, both channels rising together
    fire(0, 255);
    check("abs_pos1", bus.POS1, 0);
    check("abs_pos2", bus.POS2, 255);

    // position changed mid-pulse does not disturb the latched width
    bus.PAD1_POS = 8'd128;
    bus.PAD2_POS = 8'd77;
    trigger(128, 77);
    repeat (20) @(negedge clk);
    bus.PAD1_POS = 8'd10;
    wait_idle(2000);
    check("latched_pos1", bus.POS1, 128);

    // second falling edge during a pulse is ignored
    bus.PAD1_POS = 8'd50;
    bus.PAD2_POS = 8'd200;
    trigger(50, 200);
    repeat (30) @(negedge clk);
    bus.PAD_TRG_N = 1'b0;
    repeat (3) @(negedge clk);
    bus.PAD_TRG_N = 1'b1;
    wait_idle(2000);
    fire(50, 200);

    // relative mode: DN on p1 saturates at 255, UP+DN on p2 holds
    do_reset();
    bus.MODE   = 2'b11;
    bus.PAD_DN = 2'b11;
    bus.PAD_UP = 2'b10;
    r1 = 128;
    for (int k = 0; k < 40; k++) begin
      fire(r1, 128);
      if (k == 32) check("sat_frame33", bus.POS1, 255);
      r1 = (r1 + SPD > 255) ? 255 : r1 + SPD;
    end
    bus.PAD_DN = 2'b00;
    bus.PAD_UP = 2'b01;
    for (int k = 0; k < 3; k++) begin
      fire(r1, 128);
      r1 = (r1 < SPD) ? 0 : r1 - SPD;
    end

    // async reset mid-pulse restores the relative register to 128
    trigger(r1, 128);
    repeat (20) @(negedge clk);
    do_reset();
    bus.PAD_UP = 2'b00;
    repeat (2) @(negedge clk);
    fire(128, 128);

    repeat (5) @(negedge clk);
    check("queues_drained", q1.size() + q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
